// File: rtl/i2c_byte_master_if.sv
// rtl/i2c_byte_master_if.sv - Avalon-MM register port and open-drain I2C pin bundle
interface i2c_byte_master_if;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic        busy;
   logic        scl_oe;
   logic        sda_oe;
   logic        sda_in;

   modport master (
      output address, write, writedata, read, sda_in,
      input  readdata, busy, scl_oe, sda_oe
   );

   modport slave (
      input  address, write, writedata, read, sda_in,
      output readdata, busy, scl_oe, sda_oe
   );
endinterface

// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - Avalon-MM byte-level I2C master driving open-drain SCL/SDA
// One CMD write per byte: optional START, 8 data bits, ACK bit, optional STOP.
module i2c_byte_master #(
   parameter int QTR_DIV = 125
) (
   input logic              clk,
   input logic              reset_n,
   i2c_byte_master_if.slave bus
);
   localparam int CW = $clog2(QTR_DIV);
   localparam logic [CW-1:0] QTR_LAST = CW'(QTR_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_ACK, S_STOP, S_HOLD} state_t;

   state_t      r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]  r_qtr;
   logic [2:0]  r_bit;
   logic [7:0]  r_tx;
   logic [7:0]  r_shift;
   logic [7:0]  r_rx;
   logic        r_stop;
   logic        r_rd;
   logic        r_nack;
   logic        r_ack_err;
   logic        r_busy;
   logic        r_scl_oe;
   logic        r_sda_oe;
   logic [31:0] r_readdata;

   logic w_accept;
   logic w_qtr_end;
   logic w_sample;
   logic w_bit_end;
   logic w_scl_low;
   logic w_unused;

   assign w_accept  = bus.write && (bus.address == 2'd0) && !r_busy;
   assign w_qtr_end = (r_cnt == QTR_LAST);
   assign w_sample  = w_qtr_end && (r_qtr == 2'd2);
   assign w_bit_end = w_qtr_end && (r_qtr == 2'd3);
   assign w_scl_low = (r_qtr == 2'd0) || (r_qtr == 2'd3);
   assign w_unused  = &{1'b0, bus.read, bus.writedata[31:12]};

   assign bus.readdata = r_readdata;
   assign bus.busy     = r_busy;
   assign bus.scl_oe   = r_scl_oe;
   assign bus.sda_oe   = r_sda_oe;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_qtr      <= 2'd0;
         r_bit      <= 3'd0;
         r_tx       <= 8'd0;
         r_shift    <= 8'd0;
         r_rx       <= 8'd0;
         r_stop     <= 1'b0;
         r_rd       <= 1'b0;
         r_nack     <= 1'b0;
         r_ack_err  <= 1'b0;
         r_busy     <= 1'b0;
         r_scl_oe   <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_readdata <= 32'd0;
      end else begin
         case (bus.address)
            2'd1:    r_readdata <= {24'd0, r_rx};
            2'd2:    r_readdata <= {30'd0, r_ack_err, r_busy};
            default: r_readdata <= 32'd0;
         endcase

         // Pin drive follows the current phase one cycle later; IDLE and HOLD keep the bus as left.
         case (r_state)
            S_START: begin
               r_scl_oe <= (r_qtr == 2'd3);
               r_sda_oe <= r_qtr[1];
            end
            S_BITS: begin
               r_scl_oe <= w_scl_low;
               r_sda_oe <= ~r_rd & ~r_tx[r_bit];
            end
            S_ACK: begin
               r_scl_oe <= w_scl_low;
               r_sda_oe <= r_rd & ~r_nack;
            end
            S_STOP: begin
               r_scl_oe <= (r_qtr == 2'd0);
               r_sda_oe <= ~r_qtr[1];
            end
            default: begin
            end
         endcase

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy  <= 1'b1;
                  r_tx    <= bus.writedata[7:0];
                  r_stop  <= bus.writedata[9];
                  r_rd    <= bus.writedata[10];
                  r_nack  <= bus.writedata[11];
                  r_bit   <= 3'd7;
                  r_qtr   <= 2'd0;
                  r_cnt   <= '0;
                  r_state <= bus.writedata[8] ? S_START : S_BITS;
                  if (!bus.writedata[10]) begin
                     r_ack_err <= 1'b0;
                  end
               end
            end
            S_HOLD: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_cnt <= w_qtr_end ? '0 : r_cnt + 1'b1;
               if (w_qtr_end) begin
                  r_qtr <= r_qtr + 1'b1;
               end
               if (w_sample && r_state == S_BITS) begin
                  r_shift <= {r_shift[6:0], bus.sda_in};
               end
               if (w_sample && r_state == S_ACK && !r_rd) begin
                  r_ack_err <= bus.sda_in;
               end
               if (w_bit_end) begin
                  case (r_state)
                     S_START: r_state <= S_BITS;
                     S_BITS: begin
                        r_bit <= r_bit - 1'b1;
                        if (r_bit == 3'd0) begin
                           r_state <= S_ACK;
                        end
                     end
                     S_ACK: begin
                        if (r_rd) begin
                           r_rx <= r_shift;
                        end
                        r_state <= r_stop ? S_STOP : S_HOLD;
                     end
                     default: r_state <= S_HOLD;
                  endcase
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - table and randomized checks of i2c_byte_master against a bus-level slave model
module tb_i2c_byte_master;
   localparam int Q = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   i2c_byte_master_if bus();

   i2c_byte_master #(.QTR_DIV(Q)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad = 0;

   // Slave setup written by the stimulus; bus observation owned by the monitor.
   int         cmd_seq = 0;
   logic       slv_read = 1'b0;
   logic       slv_start = 1'b0;
   logic       slv_ack = 1'b0;
   logic [7:0] slv_byte = 8'd0;
   logic       slv_rel = 1'b1;
   logic       mon_bits[$];
   int         scl_edges = 0;
   int         starts = 0;
   int         stops = 0;
   logic       drove = 1'b0;

   logic [7:0] m_rx = 8'd0;
   logic       m_ack_err = 1'b0;

   assign bus.sda_in = ~bus.sda_oe & slv_rel;

   function automatic logic slave_bit(input int k);
      if (slv_read) return (k < 8) ? slv_byte[7-k] : 1'b1;
      return (k == 8) ? slv_ack : 1'b1;
   endfunction

   initial begin
      logic scl_n, sda_n, prev_scl, prev_sda;
      int   k, seen;
      prev_scl = 1'b1; prev_sda = 1'b1; k = 0; seen = 0;
      forever begin
         @(negedge clk);
         scl_n = ~bus.scl_oe;
         sda_n = ~bus.sda_oe & slv_rel;
         if (cmd_seq != seen) begin
            seen = cmd_seq;
            mon_bits.delete();
            k = 0;
            drove = 1'b0;
            slv_rel = (!slv_start && !scl_n) ? slave_bit(0) : 1'b1;
         end
         if (scl_n != prev_scl) scl_edges++;
         if (prev_scl && scl_n && prev_sda && !sda_n) begin
            starts++;
            mon_bits.delete();
            k = 0;
         end else if (prev_scl && scl_n && !prev_sda && sda_n) begin
            stops++;
            if (mon_bits.size() > 0) void'(mon_bits.pop_back());
         end else if (!prev_scl && scl_n) begin
            mon_bits.push_back(sda_n);
            k++;
         end else if (prev_scl && !scl_n) begin
            slv_rel = slave_bit(k);
         end
         if (bus.sda_oe && k < 9) drove = 1'b1;
         prev_scl = scl_n;
         prev_sda = sda_n;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      bus.address = a;
      bus.read = 1'b1;
      tick();
      d = bus.readdata;
      bus.read = 1'b0;
      bus.address = 2'd0;
   endtask

   task automatic run_cmd(input logic [11:0] cmd, input logic [7:0] sbyte, input logic sack,
                          input int late_at, input logic [11:0] late_cmd,
                          output logic [31:0] status, output logic [31:0] rxd);
      int s0, p0, n, lat;
      logic [8:0] got, want;
      s0 = starts;
      p0 = stops;
      slv_read = cmd[10];
      slv_start = cmd[8];
      slv_byte = sbyte;
      slv_ack = sack;
      cmd_seq++;
      bus.address = 2'd0;
      bus.writedata = {20'd0, cmd};
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      n = 0;
      while (bus.busy && n < 1000) begin
         n++;
         if (n == late_at) begin
            bus.writedata = {20'd0, late_cmd};
            bus.write = 1'b1;
         end
         tick();
         bus.write = 1'b0;
      end
      lat = 36*Q + 1 + (cmd[8] ? 4*Q : 0) + (cmd[9] ? 4*Q : 0);
      check("busy_cycles", n, lat);
      want = cmd[10] ? {sbyte, cmd[11]} : {cmd[7:0], sack};
      for (int i = 0; i < 9; i++) got[8-i] = (i < mon_bits.size()) ? mon_bits[i] : 1'bx;
      check("bit_count", mon_bits.size(), 9);
      check("bus_bits", {23'd0, got}, {23'd0, want});
      check("start_seen", starts - s0, {31'd0, cmd[8]});
      check("stop_seen", stops - p0, {31'd0, cmd[9]});
      if (cmd[10]) m_rx = sbyte;
      else m_ack_err = sack;
      read_reg(2'd2, status);
      check("status_model", status, {30'd0, m_ack_err, 1'b0});
      read_reg(2'd1, rxd);
      check("rxdata_model", rxd, {24'd0, m_rx});
   endtask

   typedef struct {
      logic [11:0] cmd;
      logic [7:0]  sbyte;
      logic        sack;
      logic [31:0] exp_status;
      logic [31:0] exp_rx;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1);
   end

   initial begin
      logic [31:0] st, rx;
      int highs, e0;
      vecs[0] = '{12'h3A5, 8'h00, 1'b0, 32'h0, 32'h00};
      vecs[1] = '{12'h155, 8'h00, 1'b1, 32'h2, 32'h00};
      vecs[2] = '{12'h2AA, 8'h00, 1'b0, 32'h0, 32'h00};
      vecs[3] = '{12'hF00, 8'h3C, 1'b0, 32'h0, 32'h3C};
      vecs[4] = '{12'hE00, 8'hC3, 1'b0, 32'h0, 32'hC3};
      vecs[5] = '{12'h555, 8'h5A, 1'b0, 32'h0, 32'h5A};
      vecs[6] = '{12'h1FE, 8'h00, 1'b1, 32'h2, 32'h5A};
      vecs[7] = '{12'hE00, 8'h81, 1'b0, 32'h2, 32'h81};
      vecs[8] = '{12'h300, 8'h00, 1'b0, 32'h0, 32'h81};

      bus.address = 2'd0;
      bus.write = 1'b0;
      bus.writedata = 32'd0;
      bus.read = 1'b0;
      repeat (3) tick();
      check("reset_readdata", bus.readdata, 32'd0);
      check("reset_pins", {29'd0, bus.busy, bus.scl_oe, bus.sda_oe}, 32'd0);
      reset_n = 1'b1;
      tick();
      read_reg(2'd2, st);
      check("reset_status", st, 32'd0);
      read_reg(2'd1, rx);
      check("reset_rxdata", rx, 32'd0);

      for (int i = 0; i < 9; i++) begin
         run_cmd(vecs[i].cmd, vecs[i].sbyte, vecs[i].sack, 0, 12'd0, st, rx);
         check($sformatf("vec%0d_status", i), st, vecs[i].exp_status);
         check($sformatf("vec%0d_rxdata", i), rx, vecs[i].exp_rx);
         if (vecs[i].cmd[10] && !vecs[i].cmd[8]) check($sformatf("vec%0d_ack_release", i), {31'd0, drove}, 32'd0);
         repeat (3) tick();
      end

      // Second CMD while busy must be dropped.
      run_cmd(12'h3A5, 8'h00, 1'b0, 10, 12'h1FF, st, rx);
      highs = 0;
      repeat (40) begin
         tick();
         if (bus.busy) highs++;
      end
      check("dropped_cmd_busy", highs, 0);

      // Repeated start: SCL stays low between the two bytes.
      run_cmd(12'h1A0, 8'h00, 1'b0, 0, 12'd0, st, rx);
      repeat (5) tick();
      check("scl_held_low", {31'd0, bus.scl_oe}, 32'd1);
      run_cmd(12'h1A1, 8'h00, 1'b0, 0, 12'd0, st, rx);
      run_cmd(12'h200, 8'h00, 1'b0, 0, 12'd0, st, rx);

      for (int i = 0; i < 24; i++) begin
         run_cmd(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 0, 12'd0, st, rx);
         repeat (2) tick();
      end
      run_cmd(12'h300, 8'h00, 1'b0, 0, 12'd0, st, rx);

      // Asynchronous reset in the middle of a byte.
      slv_read = 1'b0; slv_start = 1'b1; slv_ack = 1'b0;
      cmd_seq++;
      bus.writedata = 32'h3A5;
      bus.write = 1'b1;
      tick();
      bus.write = 1'b0;
      bus.address = 2'd2;
      repeat (60) tick();
      check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_readdata", bus.readdata, 32'd0);
      check("midrst_pins", {29'd0, bus.busy, bus.scl_oe, bus.sda_oe}, 32'd0);
      repeat (2) tick();
      e0 = scl_edges;
      reset_n = 1'b1;
      bus.address = 2'd0;
      repeat (50) tick();
      check("post_reset_scl_edges", scl_edges - e0, 0);
      check("post_reset_busy", {31'd0, bus.busy}, 32'd0);
      m_ack_err = 1'b0;
      m_rx = 8'd0;
      run_cmd(12'h3A5, 8'h00, 1'b0, 0, 12'd0, st, rx);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
